// File: rtl/rx_acq_sequencer.sv
// Acquisition controller: phase config shadowing, generator gating, settle/capture sequencing
// and a 4-channel frame serializer with valid/ready; frames arriving while the buffer is busy are dropped.
module rx_acq_sequencer #(
  parameter int unsigned SETTLE = 8,
  parameter int unsigned NSAMP  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  output logic [31:0] phase1,
  output logic [31:0] phase2,
  output logic [31:0] phase3,
  output logic [31:0] phase4,
  output logic        enout,
  input  logic        endata,
  input  logic [11:0] rx1,
  input  logic [11:0] rx2,
  input  logic [11:0] rx3,
  input  logic [11:0] rx4,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic [1:0]  smp_chan,
  output logic [11:0] smp_data,
  output logic        smp_last,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam logic [7:0]  SETTLE_C = 8'(SETTLE);
  localparam logic [15:0] NSAMP_C  = 16'(NSAMP);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [3:0][31:0]   shadow_q, shadow_d;
  logic [3:0][31:0]   phase_q, phase_d;
  logic               enout_q, enout_d;
  logic               cap_q, cap_d;
  logic [7:0]         settle_cnt_q, settle_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               overrun_q, overrun_d;
  logic               done_q, done_d;
  logic [3:0][11:0]   buf_q, buf_d;
  logic               vld_q, vld_d;
  logic [1:0]         chan_q, chan_d;
  logic               last_q, last_d;

  logic hs;
  logic hs_chan3;

  assign hs       = vld_q & smp_ready;
  assign hs_chan3 = hs & (chan_q == 2'd3);

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    phase_d      = phase_q;
    enout_d      = enout_q;
    cap_d        = endata;
    settle_cnt_d = settle_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = overrun_q;
    done_d       = 1'b0;
    buf_d        = buf_q;
    vld_d        = vld_q;
    chan_d       = chan_q;
    last_d       = last_q;

    if (cfg_we) shadow_d[cfg_addr] = cfg_data;

    if (hs) begin
      if (chan_q == 2'd3) vld_d = 1'b0;
      chan_d = chan_q + 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // shadow_d already carries a same-cycle write, so it is part of the copy
        if (start && !abort) begin
          phase_d      = shadow_d;
          enout_d      = 1'b1;
          settle_cnt_d = 8'd0;
          frame_cnt_d  = 16'd0;
          overrun_d    = 1'b0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cap_q) begin
          settle_cnt_d = settle_cnt_q + 8'd1;
          if (settle_cnt_d == SETTLE_C) state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (cap_q) begin
          if (!vld_q || hs_chan3) begin
            buf_d[0]    = rx1;
            buf_d[1]    = rx2;
            buf_d[2]    = rx3;
            buf_d[3]    = rx4;
            vld_d       = 1'b1;
            chan_d      = 2'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            last_d      = (frame_cnt_d == NSAMP_C);
            if (last_d) begin
              enout_d = 1'b0;
              state_d = ST_DRAIN;
            end
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!vld_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      enout_d = 1'b0;
      vld_d   = 1'b0;
      chan_d  = 2'd0;
      last_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      phase_q      <= '0;
      enout_q      <= 1'b0;
      cap_q        <= 1'b0;
      settle_cnt_q <= 8'd0;
      frame_cnt_q  <= 16'd0;
      overrun_q    <= 1'b0;
      done_q       <= 1'b0;
      buf_q        <= '0;
      vld_q        <= 1'b0;
      chan_q       <= 2'd0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      phase_q      <= phase_d;
      enout_q      <= enout_d;
      cap_q        <= cap_d;
      settle_cnt_q <= settle_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      done_q       <= done_d;
      buf_q        <= buf_d;
      vld_q        <= vld_d;
      chan_q       <= chan_d;
      last_q       <= last_d;
    end
  end

  assign phase1    = phase_q[0];
  assign phase2    = phase_q[1];
  assign phase3    = phase_q[2];
  assign phase4    = phase_q[3];
  assign enout     = enout_q;
  assign smp_valid = vld_q;
  assign smp_chan  = chan_q;
  assign smp_data  = buf_q[chan_q];
  assign smp_last  = vld_q & last_q & (chan_q == 2'd3);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rx_acq_sequencer.sv
// Directed bench for rx_acq_sequencer (SETTLE=2, NSAMP=3): config/start, streaming,
// backpressure with frame drop, cap/handshake coincidence, abort, and reset mid-acquisition.
module tb_rx_acq_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, abort, cfg_we, endata, smp_ready;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [31:0] phase1, phase2, phase3, phase4;
  logic        enout, smp_valid, smp_last, busy, done, overrun;
  logic [11:0] rx1, rx2, rx3, rx4;
  logic [1:0]  smp_chan;
  logic [11:0] smp_data;

  int checks = 0;
  int failures = 0;

  logic       gen_on = 1'b0;
  int         gcnt = 0;
  logic [1:0]  bchan[$];
  logic [11:0] bdata[$];
  logic        blast[$];
  int          done_cnt = 0;
  int          ed_cnt = 0;
  int          ed_at_valid = 0;
  bit          valid_seen = 0;
  int          stall_changes = 0;
  bit          prev_stall = 0;
  logic [1:0]  pc;
  logic [11:0] pd;
  logic        pl;
  logic [11:0] exp_d [4] = '{12'd100, 12'hF9C, 12'd0, 12'h7FF};

  rx_acq_sequencer #(.SETTLE(2), .NSAMP(3)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .phase1(phase1), .phase2(phase2), .phase3(phase3), .phase4(phase4),
    .enout(enout), .endata(endata),
    .rx1(rx1), .rx2(rx2), .rx3(rx3), .rx4(rx4),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_chan(smp_chan),
    .smp_data(smp_data), .smp_last(smp_last),
    .busy(busy), .done(done), .overrun(overrun)
  );

  initial forever #5 clock = ~clock;

  // Sample-period strobe: one clock in every 20, first one 20 clocks after gen_on
  initial forever begin
    @(posedge clock);
    #1;
    if (gen_on) begin
      gcnt = gcnt + 1;
      if (gcnt == 20) begin
        endata = 1'b1;
        gcnt = 0;
      end else begin
        endata = 1'b0;
      end
    end else begin
      gcnt = 0;
      endata = 1'b0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (endata) ed_cnt++;
    if (smp_valid && !valid_seen) begin
      valid_seen = 1;
      ed_at_valid = ed_cnt;
    end
    if (done) done_cnt++;
    if (smp_valid && smp_ready) begin
      bchan.push_back(smp_chan);
      bdata.push_back(smp_data);
      blast.push_back(smp_last);
    end
    if (prev_stall && (!smp_valid || smp_chan != pc || smp_data != pd || smp_last != pl))
      stall_changes++;
    prev_stall = smp_valid && !smp_ready;
    pc = smp_chan;
    pd = smp_data;
    pl = smp_last;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bchan.delete();
    bdata.delete();
    blast.delete();
    done_cnt = 0;
    ed_cnt = 0;
    valid_seen = 0;
    stall_changes = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_phase1"}, phase1, 32'h0);
    chk({tag, "_phase2"}, phase2, 32'h0);
    chk({tag, "_phase3"}, phase3, 32'h0);
    chk({tag, "_phase4"}, phase4, 32'h0);
    chk({tag, "_enout"}, 32'(enout), 32'h0);
    chk({tag, "_valid"}, 32'(smp_valid), 32'h0);
    chk({tag, "_chan"}, 32'(smp_chan), 32'h0);
    chk({tag, "_data"}, 32'(smp_data), 32'h0);
    chk({tag, "_last"}, 32'(smp_last), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  task automatic wait_done(input string tag);
    int got = 0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, got, 32'd1);
    chk({tag, "_busy_with_done"}, 32'(busy), 32'h0);
    chk({tag, "_enout_off"}, 32'(enout), 32'h0);
    step(1);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'h0);
    gen_on = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int got = 0;
    for (int i = 0; i < 200; i++) begin
      if (smp_valid) begin
        got = 1;
        break;
      end
      step(1);
    end
    chk({tag, "_valid_seen"}, got, 32'd1);
  endtask

  task automatic verify_stream(input string tag);
    chk({tag, "_beats"}, bchan.size(), 32'd12);
    for (int i = 0; i < bchan.size(); i++) begin
      chk({tag, "_chan"}, 32'(bchan[i]), 32'(i % 4));
      chk({tag, "_data"}, 32'(bdata[i]), 32'(exp_d[i % 4]));
      chk({tag, "_last"}, 32'(blast[i]), (i == 11) ? 32'd1 : 32'd0);
    end
    chk({tag, "_done_count"}, done_cnt, 32'd1);
  endtask

  initial begin
    int got;
    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    cfg_addr = 2'd0; cfg_data = 32'h0; smp_ready = 1'b0;
    rx1 = 12'd100; rx2 = 12'hF9C; rx3 = 12'd0; rx4 = 12'h7FF;
    step(3);
    chk_zero("reset");
    reset = 1'b0;
    step(1);

    // Config and start
    cfg_we = 1'b1;
    cfg_addr = 2'd0; cfg_data = 32'h00100000; step(1);
    cfg_addr = 2'd1; cfg_data = 32'hFFF00000; step(1);
    cfg_addr = 2'd2; cfg_data = 32'h00000000; step(1);
    cfg_addr = 2'd3; cfg_data = 32'h7FF00000; step(1);
    cfg_we = 1'b0;
    chk("phase_before_start", phase1, 32'h0);
    start = 1'b1; step(1); start = 1'b0;
    chk("cfg_phase1", phase1, 32'h00100000);
    chk("cfg_phase2", phase2, 32'hFFF00000);
    chk("cfg_phase3", phase3, 32'h00000000);
    chk("cfg_phase4", phase4, 32'h7FF00000);
    chk("cfg_enout", 32'(enout), 32'd1);
    chk("cfg_busy", 32'(busy), 32'd1);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 32'h12345678; step(1); cfg_we = 1'b0;
    step(1);
    chk("cfg_busy_write_phase1", phase1, 32'h00100000);

    // Settle and count with smp_ready held high
    clear_mon();
    smp_ready = 1'b1;
    gen_on = 1'b1;
    wait_done("basic");
    chk("basic_caps_before_valid", ed_at_valid, 32'd3);
    verify_stream("basic");
    chk("basic_overrun", 32'(overrun), 32'h0);

    // Backpressure mid-frame
    start = 1'b1; step(1); start = 1'b0;
    chk("bp_busy", 32'(busy), 32'd1);
    clear_mon();
    gen_on = 1'b1;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (smp_valid && smp_chan == 2'd1) begin
        got = 1;
        break;
      end
      step(1);
    end
    chk("bp_reach_chan1", got, 32'd1);
    smp_ready = 1'b0;
    step(30);
    chk("bp_held_valid", 32'(smp_valid), 32'd1);
    chk("bp_held_chan", 32'(smp_chan), 32'd1);
    chk("bp_held_data", 32'(smp_data), 32'h00000F9C);
    chk("bp_overrun_set", 32'(overrun), 32'd1);
    smp_ready = 1'b1;
    wait_done("bp");
    chk("bp_stall_stable", stall_changes, 32'd0);
    verify_stream("bp");
    chk("bp_overrun_sticky", 32'(overrun), 32'd1);

    // Channel 3 handshake coincident with cap
    smp_ready = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    chk("bnd_overrun_cleared", 32'(overrun), 32'h0);
    clear_mon();
    gen_on = 1'b1;
    wait_valid("bnd");
    chk("bnd_first_chan", 32'(smp_chan), 32'd0);
    smp_ready = 1'b1;
    step(3);
    smp_ready = 1'b0;
    chk("bnd_chan3_held", 32'(smp_chan), 32'd3);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (endata) begin
        got = 1;
        break;
      end
    end
    chk("bnd_endata_seen", got, 32'd1);
    step(1);
    smp_ready = 1'b1;
    step(1);
    chk("bnd_new_frame_valid", 32'(smp_valid), 32'd1);
    chk("bnd_new_frame_chan", 32'(smp_chan), 32'd0);
    chk("bnd_overrun", 32'(overrun), 32'h0);
    wait_done("bnd");
    verify_stream("bnd");
    chk("bnd_overrun_end", 32'(overrun), 32'h0);

    // Abort in CAPTURE after one frame, then a full run
    start = 1'b1; step(1); start = 1'b0;
    clear_mon();
    gen_on = 1'b1;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (bchan.size() >= 4) begin
        got = 1;
        break;
      end
      step(1);
    end
    chk("abt_one_frame", got, 32'd1);
    abort = 1'b1; gen_on = 1'b0; step(1); abort = 1'b0;
    chk("abt_enout", 32'(enout), 32'h0);
    chk("abt_valid", 32'(smp_valid), 32'h0);
    chk("abt_busy", 32'(busy), 32'h0);
    chk("abt_phase_kept", phase1, 32'h12345678);
    step(60);
    chk("abt_no_done", done_cnt, 32'd0);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 32'hCAFEBABE; start = 1'b1;
    step(1);
    cfg_we = 1'b0; start = 1'b0;
    chk("restart_phase3_same_cycle_write", phase3, 32'hCAFEBABE);
    chk("restart_phase1", phase1, 32'h12345678);
    chk("restart_busy", 32'(busy), 32'd1);
    clear_mon();
    gen_on = 1'b1;
    step(10);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 32'hAAAA0000; start = 1'b1;
    step(1);
    cfg_we = 1'b0; start = 1'b0;
    chk("start_while_busy_phase1", phase1, 32'h12345678);
    wait_done("restart");
    verify_stream("restart");

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; step(1); start = 1'b0; abort = 1'b0;
    chk("idle_abort_wins_busy", 32'(busy), 32'h0);
    chk("idle_abort_wins_enout", 32'(enout), 32'h0);

    // Reset asserted in SETTLE, start held during reset
    start = 1'b1; step(1); start = 1'b0;
    chk("rst_settle_busy", 32'(busy), 32'd1);
    reset = 1'b1; start = 1'b1;
    step(1);
    chk_zero("midrst");
    step(3);
    chk("midrst_start_ignored", 32'(busy), 32'h0);
    reset = 1'b0; start = 1'b0;
    step(1);
    chk("postrst_busy", 32'(busy), 32'h0);
    start = 1'b1; step(1); start = 1'b0;
    chk("postrst_shadow_cleared", phase1, 32'h0);
    chk("postrst_busy_start", 32'(busy), 32'd1);
    abort = 1'b1; step(1); abort = 1'b0;
    chk("postrst_abort_idle", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
